ram_port_arbiter: RTL and testbench

- Sits between two memory masters (m0: instruction fetch, m1: data load/store) and the single 256x8 RAM.
- Grants the RAM to one master at a time using round-robin arbitration, and drives the RAM read/write/address/data lines.
- Adds a sequenced zero-fill sweep, so software can clear the RAM without asserting global reset.

---
 rtl/ram_port_arbiter_if.sv | 15 +
 rtl/ram_port_arbiter.sv | 118 +++++++++++
 tb/tb_ram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// One master-side RAM access port: request/qualifiers from the master, ack/read data back.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter granting one RAM to two masters, with a sequenced zero-fill sweep.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave m0,
  ram_port_arbiter_if.slave m1,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StClear} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              clr_pend_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Only contention consults last_grant; a lone requester simply wins.
  always_comb begin
    pick      = (m0.req && m1.req) ? ~last_grant_q : m1.req;
    sel_we    = pick ? m1.we    : m0.we;
    sel_addr  = pick ? m1.addr  : m0.addr;
    sel_wdata = pick ? m1.wdata : m0.wdata;
  end

  assign m0.ack   = ack_q[0];
  assign m1.ack   = ack_q[1];
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

  // ram_addr doubles as the sweep counter while in StClear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      clr_pend_q   <= 1'b0;
      ack_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      clr_busy     <= 1'b0;
      clr_done     <= 1'b0;
      ram_read     <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      clr_done <= 1'b0;
      ack_q    <= '0;
      if (clr_start && state_q != StClear) clr_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (clr_pend_q || clr_start) begin
            state_q    <= StClear;
            clr_pend_q <= 1'b0;
            clr_busy   <= 1'b1;
            ram_write  <= 1'b1;
            ram_addr   <= '0;
            ram_wdata  <= '0;
          end else if (m0.req || m1.req) begin
            state_q   <= StAccess;
            grant_q   <= pick;
            if (m0.req && m1.req) last_grant_q <= pick;
            ram_read  <= ~sel_we;
            ram_write <= sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_we ? sel_wdata : '0;
          end
        end
        StAccess: begin
          if (ram_read) begin
            if (grant_q) rdata1_q <= ram_rdata;
            else         rdata0_q <= ram_rdata;
          end
          ack_q     <= grant_q ? 2'b10 : 2'b01;
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          state_q   <= StResp;
        end
        StResp: state_q <= StIdle;
        StClear: begin
          if (ram_addr == LastAddr) begin
            state_q   <= StIdle;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b1;
            ram_write <= 1'b0;
            ram_addr  <= '0;
          end else begin
            ram_addr <= ram_addr + ADDR_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 256x8 RAM model.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_start = 1'b0;
  logic       clr_busy, clr_done;
  logic       ram_read, ram_write;
  logic [7:0] ram_addr, ram_wdata;
  wire  [7:0] ram_rdata;
  logic [7:0] mem [256];

  int checks = 0;
  int fails  = 0;

  ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) m0_if ();
  ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) m1_if ();

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram_read ? mem[ram_addr] : 8'bz;
  always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_wdata;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit         m;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] outs();
    return {m0_if.ack, m1_if.ack, m0_if.rdata, m1_if.rdata, clr_busy, clr_done,
            ram_read, ram_write, ram_addr, ram_wdata};
  endfunction

  // Advance to the next falling edge and check the always-true exclusions there.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      chk("rw_exclusive", {63'd0, ram_read & ram_write}, 64'd0);
      chk("ack_exclusive", {63'd0, m0_if.ack & m1_if.ack}, 64'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic access(input bit m, input bit we, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    if (m) begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
    end else begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
    end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (m ? m1_if.ack : m0_if.ack) begin
        lat = i;
        break;
      end
    end
    rd = m ? m1_if.rdata : m0_if.rdata;
    chk("other_ack_low", {63'd0, m ? m0_if.ack : m1_if.ack}, 64'd0);
    if (m) m1_if.req = 1'b0; else m0_if.req = 1'b0;
    tick();
    chk("ack_one_cycle", {63'd0, m ? m1_if.ack : m0_if.ack}, 64'd0);
  endtask

  task automatic sweep(input bit extra, output int busy_n, output int done_n, output int gap);
    int last_busy, done_i;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_n = 0; done_n = 0; last_busy = -1; done_i = -1;
    for (int i = 0; i < 400; i++) begin
      if (i == 0) begin
        chk("sweep_first_addr", {56'd0, ram_addr}, 64'd0);
        chk("sweep_first_wr", {55'd0, ram_write, ram_wdata}, {55'd0, 1'b1, 8'h00});
      end
      if (clr_busy) begin busy_n++; last_busy = i; end
      if (clr_done) begin done_n++; done_i = i; end
      clr_start = extra && clr_busy && (busy_n == 10 || busy_n == 100);
      tick();
    end
    clr_start = 1'b0;
    gap = done_i - last_busy;
  endtask

  task automatic contend_first();
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 8'h01;
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 8'h02;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m0_if.ack || m1_if.ack) break;
    end
    chk("post_reset_m0_wins", {62'd0, m0_if.ack, m1_if.ack}, 64'd2);
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    tick();
    tick();
  endtask

  vec_t       vecs [7];
  logic [7:0] rd;
  int         lat, busy_n, done_n, gap, cnt, n;
  bit         found;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[2] = '{1'b0, 1'b1, 8'h20, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'hA5, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hA5};
    vecs[6] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;

    tick();
    chk("reset_outputs", {26'd0, outs()}, 64'd0);
    do_reset();

    foreach (vecs[k]) begin
      access(vecs[k].m, vecs[k].we, vecs[k].addr, vecs[k].wdata, rd, lat);
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'd2);
      if (!vecs[k].we) chk($sformatf("vec%0d_rdata", k), {56'd0, rd}, {56'd0, vecs[k].exp_rdata});
    end

    // Contention: both held, grants must alternate starting with m0.
    do_reset();
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 8'h10;
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      for (int i = 1; i <= 6; i++) begin
        tick();
        if (m0_if.ack || m1_if.ack) begin n = i; break; end
      end
      chk($sformatf("contend%0d_gap", k), 64'(n), (k == 0) ? 64'd2 : 64'd3);
      chk($sformatf("contend%0d_order", k), {63'd0, m1_if.ack}, 64'(k % 2));
      chk($sformatf("contend%0d_rdata", k), {56'd0, m1_if.ack ? m1_if.rdata : m0_if.rdata},
          (k % 2) ? 64'h3C : 64'h5A);
    end
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    tick();

    // Zero-fill sweep over preloaded locations.
    access(1'b0, 1'b1, 8'h00, 8'hFF, rd, lat);
    access(1'b1, 1'b1, 8'h7F, 8'hFF, rd, lat);
    access(1'b0, 1'b1, 8'hFF, 8'hFF, rd, lat);
    sweep(1'b0, busy_n, done_n, gap);
    chk("sweep_busy_cycles", 64'(busy_n), 64'd256);
    chk("sweep_done_pulses", 64'(done_n), 64'd1);
    chk("sweep_done_follows", 64'(gap), 64'd1);
    access(1'b0, 1'b0, 8'h00, 8'h00, rd, lat);
    chk("cleared_00", {56'd0, rd}, 64'd0);
    access(1'b1, 1'b0, 8'h7F, 8'h00, rd, lat);
    chk("cleared_7f", {56'd0, rd}, 64'd0);
    access(1'b0, 1'b0, 8'hFF, 8'h00, rd, lat);
    chk("cleared_ff", {56'd0, rd}, 64'd0);

    // clr_start pulses during CLEAR are ignored.
    sweep(1'b1, busy_n, done_n, gap);
    chk("resweep_busy_cycles", 64'(busy_n), 64'd256);
    chk("resweep_done_pulses", 64'(done_n), 64'd1);

    // clr_start during an m0 access with m1 waiting.
    do_reset();
    access(1'b0, 1'b1, 8'h30, 8'h11, rd, lat);
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 8'h30;
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 8'h30;
    tick();
    chk("cda_access", {55'd0, ram_read, ram_addr}, {55'd0, 1'b1, 8'h30});
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("cda_m0_ack", {62'd0, m0_if.ack, m1_if.ack}, 64'd2);
    chk("cda_m0_rdata", {56'd0, m0_if.rdata}, 64'h11);
    m0_if.req = 1'b0;
    tick();
    chk("cda_idle_gap", {63'd0, clr_busy}, 64'd0);
    tick();
    chk("cda_clear_starts", {63'd0, clr_busy}, 64'd1);
    cnt = 0; found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (m1_if.ack) cnt++;
      if (clr_done) begin found = 1'b1; break; end
    end
    chk("cda_done_seen", {63'd0, found}, 64'd1);
    chk("cda_no_ack_in_clear", 64'(cnt), 64'd0);
    tick();
    tick();
    chk("cda_m1_after_done", {63'd0, m1_if.ack}, 64'd1);
    chk("cda_m1_rdata", {56'd0, m1_if.rdata}, 64'd0);
    m1_if.req = 1'b0;
    tick();

    // Reset during ACCESS.
    m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 8'h40; m0_if.wdata = 8'h77;
    tick();
    chk("rst_acc_writing", {63'd0, ram_write}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_acc_outputs", {26'd0, outs()}, 64'd0);
    m0_if.req = 1'b0;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m0_if.ack || m1_if.ack || clr_done) cnt++;
    end
    chk("rst_acc_no_ack", 64'(cnt), 64'd0);
    contend_first();

    // Reset at sweep address 0x40.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (clr_busy && ram_addr == 8'h40) begin found = 1'b1; break; end
      tick();
    end
    chk("rst_sweep_reached", {63'd0, found}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_sweep_outputs", {26'd0, outs()}, 64'd0);
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (clr_busy || clr_done) cnt++;
    end
    chk("rst_sweep_not_resumed", 64'(cnt), 64'd0);
    contend_first();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
